// File: rtl/posit_defines.sv
// Shared field layouts and packed types for the raw (extractor) and sum
// (normalizer input) posit formats, es=2.
package posit_defines;

  localparam int unsigned POSIT_SERIALIZED_WIDTH_ES2     = 38;
  localparam int unsigned POSIT_SERIALIZED_WIDTH_SUM_ES2 = 42;

  localparam int unsigned RAW_SIGN_BIT  = 37;
  localparam int unsigned RAW_SCALE_MSB = 36;
  localparam int unsigned RAW_SCALE_LSB = 29;
  localparam int unsigned RAW_FRAC_MSB  = 28;
  localparam int unsigned RAW_FRAC_LSB  = 2;
  localparam int unsigned RAW_INF_BIT   = 1;
  localparam int unsigned RAW_ZERO_BIT  = 0;

  localparam int unsigned SUM_SIGN_BIT  = 41;
  localparam int unsigned SUM_SCALE_MSB = 40;
  localparam int unsigned SUM_SCALE_LSB = 33;
  localparam int unsigned SUM_FRAC_MSB  = 32;
  localparam int unsigned SUM_FRAC_LSB  = 2;
  localparam int unsigned SUM_INF_BIT   = 1;
  localparam int unsigned SUM_ZERO_BIT  = 0;

  localparam int unsigned GUARD_W = 4;

  typedef struct packed {
    logic        sign;
    logic [7:0]  scale;
    logic [26:0] frac;
    logic        inf;
    logic        zero;
  } posit_raw_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  scale;
    logic [30:0] frac;
    logic        inf;
    logic        zero;
  } posit_sum_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  scale;
    logic [26:0] frac;
  } operand_t;

  // Per-stage control carried alongside the datapath
  typedef struct packed {
    logic       special;
    posit_sum_t spec;
    logic       sign;
    logic [7:0] scale;
  } ctl_t;

  function automatic posit_sum_t widen(input posit_raw_t x);
    posit_sum_t s;
    s       = '0;
    s.sign  = x.sign;
    s.scale = x.scale;
    s.frac  = {x.frac, {GUARD_W{1'b0}}};
    s.inf   = x.inf;
    s.zero  = x.zero;
    return s;
  endfunction

endpackage

// File: rtl/posit_lzc.sv
// Parameterized leading-zero counter; all-zero input yields W.
module posit_lzc #(
  parameter int unsigned W  = 34,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  always_comb begin
    count = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/posit_raw_adder_p8.sv
// 8-stage pipelined adder for raw es=2 posits: specials/compare, swap,
// align (2), add, lzc, shift, pack. Output is unrounded with a sticky flag.
module posit_raw_adder_p8
  import posit_defines::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned ES      = 2,
  parameter int unsigned LATENCY = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]     in1,
  input  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]     in2,
  input  logic                                      start,
  output logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] result,
  output logic                                      done,
  output logic                                      truncated
);

  localparam int unsigned FRAC_W = N - ES - 3;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned WORK_W = SIG_W + GUARD_W + 2;
  localparam int unsigned CNT_W  = $clog2(WORK_W + 1);
  localparam int unsigned PAD_W  = WORK_W - SIG_W - 1;

  logic [LATENCY-1:0] vld_q;
  posit_raw_t a_in, b_in;
  posit_sum_t spec_in;
  logic       special_in, a_ge_in;

  operand_t   a1, b1;
  logic       a_ge1, sp1;
  posit_sum_t spec1;

  ctl_t       ctl_nx;
  ctl_t       ctl_q [2:7];
  logic [7:0]        small_scale2;
  logic [FRAC_W-1:0] big_frac2, small_frac2;
  logic              sub2;

  logic [8:0]        diff;
  logic [WORK_W-1:0] big_sig3, small_sig3;
  logic [CNT_W-1:0]  d3;
  logic              sub3;

  logic [2*WORK_W-1:0] sh_full;
  logic [WORK_W-1:0]   big_sig4, sh4;
  logic                sticky4, sub4;

  logic [WORK_W-1:0] sum5, sum6;
  logic              sticky5, sticky6, sticky7;
  logic [CNT_W-1:0]  lzc_cnt, lzc6;

  logic [WORK_W-1:0]        norm_full;
  logic [WORK_W-2:0]        norm7;
  logic signed [8:0]        scale_nx, scale7;
  logic                     zero7;

  posit_sum_t res_nx, res_q;
  logic       trunc_nx, trunc_q;

  always_comb begin
    a_in.sign  = in1[RAW_SIGN_BIT];
    a_in.scale = in1[RAW_SCALE_MSB:RAW_SCALE_LSB];
    a_in.frac  = in1[RAW_FRAC_MSB:RAW_FRAC_LSB];
    a_in.inf   = in1[RAW_INF_BIT];
    a_in.zero  = in1[RAW_ZERO_BIT];
    b_in.sign  = in2[RAW_SIGN_BIT];
    b_in.scale = in2[RAW_SCALE_MSB:RAW_SCALE_LSB];
    b_in.frac  = in2[RAW_FRAC_MSB:RAW_FRAC_LSB];
    b_in.inf   = in2[RAW_INF_BIT];
    b_in.zero  = in2[RAW_ZERO_BIT];
  end

  always_comb begin
    spec_in    = '0;
    special_in = 1'b1;
    if (a_in.inf | b_in.inf)        spec_in.inf  = 1'b1;
    else if (a_in.zero & b_in.zero) spec_in.zero = 1'b1;
    else if (a_in.zero)             spec_in = widen(b_in);
    else if (b_in.zero)             spec_in = widen(a_in);
    else                            special_in = 1'b0;
    // Biasing the scale sign bit turns the signed compare into an unsigned one
    a_ge_in = {~a_in.scale[7], a_in.scale[6:0], a_in.frac} >=
              {~b_in.scale[7], b_in.scale[6:0], b_in.frac};
  end

  always_comb begin
    ctl_nx.special = sp1;
    ctl_nx.spec    = spec1;
    ctl_nx.sign    = a_ge1 ? a1.sign  : b1.sign;
    ctl_nx.scale   = a_ge1 ? a1.scale : b1.scale;
  end

  always_comb begin
    diff    = {ctl_q[2].scale[7], ctl_q[2].scale} - {small_scale2[7], small_scale2};
    sh_full = {small_sig3, {WORK_W{1'b0}}} >> d3;
  end

  posit_lzc #(.W(WORK_W), .CW(CNT_W)) u_lzc (
    .value (sum5),
    .count (lzc_cnt)
  );

  always_comb begin
    norm_full = sum6 << lzc6;
    scale_nx  = $signed({ctl_q[6].scale[7], ctl_q[6].scale}) + 9'sd1
              - $signed({{(9-CNT_W){1'b0}}, lzc6});
  end

  always_comb begin
    res_nx   = '0;
    trunc_nx = 1'b0;
    if (ctl_q[7].special) begin
      res_nx = ctl_q[7].spec;
    end else if (zero7) begin
      res_nx.zero = 1'b1;
    end else begin
      res_nx.sign = ctl_q[7].sign;
      if (scale7 > 9'sd127)       res_nx.scale = 8'h7F;
      else if (scale7 < -9'sd128) res_nx.scale = 8'h80;
      else                        res_nx.scale = scale7[7:0];
      res_nx.frac = norm7[WORK_W-2:2];
      trunc_nx    = (|norm7[1:0]) | sticky7;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      a1           <= '0;
      b1           <= '0;
      a_ge1        <= 1'b0;
      sp1          <= 1'b0;
      spec1        <= '0;
      for (int unsigned k = 2; k <= 7; k++) ctl_q[k] <= '0;
      small_scale2 <= '0;
      big_frac2    <= '0;
      small_frac2  <= '0;
      sub2         <= 1'b0;
      big_sig3     <= '0;
      small_sig3   <= '0;
      d3           <= '0;
      sub3         <= 1'b0;
      big_sig4     <= '0;
      sh4          <= '0;
      sticky4      <= 1'b0;
      sub4         <= 1'b0;
      sum5         <= '0;
      sticky5      <= 1'b0;
      sum6         <= '0;
      lzc6         <= '0;
      sticky6      <= 1'b0;
      norm7        <= '0;
      scale7       <= '0;
      zero7        <= 1'b0;
      sticky7      <= 1'b0;
      res_q        <= '0;
      trunc_q      <= 1'b0;
    end else begin
      vld_q        <= {vld_q[LATENCY-2:0], start};
      a1           <= '{sign: a_in.sign, scale: a_in.scale, frac: a_in.frac};
      b1           <= '{sign: b_in.sign, scale: b_in.scale, frac: b_in.frac};
      a_ge1        <= a_ge_in;
      sp1          <= special_in;
      spec1        <= spec_in;
      ctl_q[2]     <= ctl_nx;
      for (int unsigned k = 3; k <= 7; k++) ctl_q[k] <= ctl_q[k-1];
      small_scale2 <= a_ge1 ? b1.scale : a1.scale;
      big_frac2    <= a_ge1 ? a1.frac  : b1.frac;
      small_frac2  <= a_ge1 ? b1.frac  : a1.frac;
      sub2         <= a1.sign ^ b1.sign;
      big_sig3     <= {2'b01, big_frac2, {PAD_W{1'b0}}};
      small_sig3   <= {2'b01, small_frac2, {PAD_W{1'b0}}};
      d3           <= (diff > 9'(WORK_W)) ? CNT_W'(WORK_W) : diff[CNT_W-1:0];
      sub3         <= sub2;
      big_sig4     <= big_sig3;
      sh4          <= sh_full[2*WORK_W-1:WORK_W];
      sticky4      <= |sh_full[WORK_W-1:0];
      sub4         <= sub3;
      // Subtracting the sticky as one LSB keeps the upper bits an exact floor
      sum5         <= sub4 ? (big_sig4 - sh4 - WORK_W'(sticky4)) : (big_sig4 + sh4);
      sticky5      <= sticky4;
      sum6         <= sum5;
      lzc6         <= lzc_cnt;
      sticky6      <= sticky5;
      norm7        <= norm_full[WORK_W-2:0];
      scale7       <= scale_nx;
      zero7        <= ~norm_full[WORK_W-1];
      sticky7      <= sticky6;
      res_q        <= res_nx;
      trunc_q      <= trunc_nx;
    end
  end

  assign done      = vld_q[LATENCY-1];
  assign truncated = trunc_q;
  assign result[SUM_SIGN_BIT]                = res_q.sign;
  assign result[SUM_SCALE_MSB:SUM_SCALE_LSB] = res_q.scale;
  assign result[SUM_FRAC_MSB:SUM_FRAC_LSB]   = res_q.frac;
  assign result[SUM_INF_BIT]                 = res_q.inf;
  assign result[SUM_ZERO_BIT]                = res_q.zero;

endmodule

// File: tb/tb_posit_raw_adder_p8.sv
// Directed and streamed checks of posit_raw_adder_p8 against an exact
// wide-integer model of the unrounded sum.
module tb_posit_raw_adder_p8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] in1 = '0;
  logic [37:0] in2 = '0;
  logic        start = 1'b0;
  logic [41:0] result;
  logic        done;
  logic        truncated;

  int nvec = 0;
  int nerr = 0;

  posit_raw_adder_p8 #(.N(32), .ES(2), .LATENCY(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in2       (in2),
    .start     (start),
    .result    (result),
    .done      (done),
    .truncated (truncated)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk(input logic s, input logic [7:0] sc,
                                     input logic [26:0] f, input logic inf, input logic z);
    return {s, sc, f, inf, z};
  endfunction

  function automatic logic [41:0] mks(input logic s, input logic [7:0] sc,
                                      input logic [30:0] f, input logic inf, input logic z);
    return {s, sc, f, inf, z};
  endfunction

  // Exact model: every operand placed on a common 2^-155 grid
  function automatic void model(input logic [37:0] a, input logic [37:0] b,
                                output logic [41:0] r, output logic t);
    logic [300:0] ma, mb, m, tt;
    logic sgn;
    int sha, shb, p, sc;
    r = '0;
    t = 1'b0;
    if (a[1] || b[1]) begin r[1] = 1'b1; return; end
    if (a[0] && b[0]) begin r[0] = 1'b1; return; end
    if (a[0]) begin r = {b[37:2], 4'b0000, 2'b00}; return; end
    if (b[0]) begin r = {a[37:2], 4'b0000, 2'b00}; return; end
    sha = int'($signed(a[36:29])) + 128;
    shb = int'($signed(b[36:29])) + 128;
    ma = 301'({1'b1, a[28:2]}) << sha;
    mb = 301'({1'b1, b[28:2]}) << shb;
    if (a[37] == b[37]) begin m = ma + mb; sgn = a[37]; end
    else if (ma > mb)   begin m = ma - mb; sgn = a[37]; end
    else if (mb > ma)   begin m = mb - ma; sgn = b[37]; end
    else begin r[0] = 1'b1; return; end
    p = 0;
    for (int i = 0; i < 301; i++) if (m[i]) p = i;
    tt = m << (300 - p);
    sc = p - 155;
    if (sc > 127)  sc = 127;
    if (sc < -128) sc = -128;
    r = {sgn, sc[7:0], tt[299:269], 2'b00};
    t = |tt[268:0];
  endfunction

  task automatic gen_pair(output logic [37:0] a, output logic [37:0] b);
    int mode, sbi;
    a = mk(1'($urandom), 8'($urandom), 27'($urandom),
           $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
    b = mk(1'($urandom), 8'($urandom), 27'($urandom),
           $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
    mode = int'($urandom_range(0, 9));
    if (mode >= 4 && mode <= 7) begin
      sbi = int'($signed(a[36:29])) + int'($urandom_range(0, 6)) - 3;
      if (sbi > 127)  sbi = 127;
      if (sbi < -128) sbi = -128;
      b[36:29] = 8'(sbi);
    end else if (mode == 8) begin
      b = a;
      b[37] = ~a[37];
    end else if (mode == 9) begin
      b = a;
      b[37] = ~a[37];
      b[5:2] = 4'($urandom);
    end
  endtask

  // Drives one operation and observes the window that follows it
  task automatic run_op(input logic [37:0] a, input logic [37:0] b,
                        output logic [41:0] r, output logic t, output int lat, output int nd);
    @(posedge clk); #1;
    in1 = a; in2 = b; start = 1'b1;
    lat = 0; nd = 0; r = '0; t = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        nd++;
        if (lat == 0) begin lat = c; r = result; t = truncated; end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
    nvec++; if (result !== 42'h0) begin nerr++; $display("FAIL reset_result: got %h want 0", result); end
    nvec++; if (truncated !== 1'b0) begin nerr++; $display("FAIL reset_trunc: got %b want 0", truncated); end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    logic [41:0] r; logic t; int lat, nd;
    run_op(mk(0, 8'd0, 27'd0, 0, 0), mk(0, 8'd0, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (lat !== 8) begin nerr++; $display("FAIL timing_latency: got %0d want 8", lat); end
    nvec++; if (nd !== 1) begin nerr++; $display("FAIL timing_done_count: got %0d want 1", nd); end
    nvec++; if (r !== mks(0, 8'd1, 31'd0, 0, 0)) begin nerr++; $display("FAIL timing_1p1: got %h want %h", r, mks(0, 8'd1, 31'd0, 0, 0)); end
    nvec++; if (t !== 1'b0) begin nerr++; $display("FAIL timing_trunc: got %b want 0", t); end
  endtask

  task automatic test_carry();
    logic [41:0] r; logic t; int lat, nd;
    run_op(mk(0, 8'd0, 27'h4000000, 0, 0), mk(0, 8'd0, 27'h4000000, 0, 0), r, t, lat, nd);
    nvec++; if (r !== mks(0, 8'd1, 31'h40000000, 0, 0)) begin nerr++; $display("FAIL carry_result: got %h want %h", r, mks(0, 8'd1, 31'h40000000, 0, 0)); end
    nvec++; if (t !== 1'b0) begin nerr++; $display("FAIL carry_trunc: got %b want 0", t); end
  endtask

  task automatic test_cancel();
    logic [41:0] r; logic t; int lat, nd;
    run_op(mk(0, 8'd0, 27'd0, 0, 0), mk(1, 8'd0, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (r !== 42'h1) begin nerr++; $display("FAIL cancel_result: got %h want 1", r); end
    nvec++; if (t !== 1'b0) begin nerr++; $display("FAIL cancel_trunc: got %b want 0", t); end
  endtask

  task automatic test_sticky();
    logic [41:0] r; logic t; int lat, nd;
    run_op(mk(0, 8'd0, 27'd0, 0, 0), mk(0, 8'hD8, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (r !== mks(0, 8'd0, 31'd0, 0, 0)) begin nerr++; $display("FAIL sticky40_result: got %h want 0", r); end
    nvec++; if (t !== 1'b1) begin nerr++; $display("FAIL sticky40_trunc: got %b want 1", t); end
    run_op(mk(0, 8'd0, 27'd0, 0, 0), mk(0, 8'hE1, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (r !== mks(0, 8'd0, 31'h1, 0, 0)) begin nerr++; $display("FAIL sticky31_result: got %h want %h", r, mks(0, 8'd0, 31'h1, 0, 0)); end
    nvec++; if (t !== 1'b0) begin nerr++; $display("FAIL sticky31_trunc: got %b want 0", t); end
    run_op(mk(0, 8'd0, 27'd0, 0, 0), mk(1, 8'hD8, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (r !== mks(0, 8'hFF, 31'h7FFFFFFF, 0, 0)) begin nerr++; $display("FAIL sticky_sub_result: got %h want %h", r, mks(0, 8'hFF, 31'h7FFFFFFF, 0, 0)); end
    nvec++; if (t !== 1'b1) begin nerr++; $display("FAIL sticky_sub_trunc: got %b want 1", t); end
  endtask

  task automatic test_specials();
    logic [41:0] r; logic t; int lat, nd;
    run_op(mk(0, 8'd0, 27'd0, 1, 0), mk(0, 8'd1, 27'h4000000, 0, 0), r, t, lat, nd);
    nvec++; if (r !== 42'h2) begin nerr++; $display("FAIL nar_result: got %h want 2", r); end
    nvec++; if (t !== 1'b0) begin nerr++; $display("FAIL nar_trunc: got %b want 0", t); end
    run_op(mk(0, 8'd0, 27'd0, 0, 1), mk(1, 8'd1, 27'h2000000, 0, 0), r, t, lat, nd);
    nvec++; if (r !== mks(1, 8'd1, 31'h20000000, 0, 0)) begin nerr++; $display("FAIL zero_plus_result: got %h want %h", r, mks(1, 8'd1, 31'h20000000, 0, 0)); end
    nvec++; if (t !== 1'b0) begin nerr++; $display("FAIL zero_plus_trunc: got %b want 0", t); end
    run_op(mk(1, 8'd1, 27'h2000000, 0, 0), mk(0, 8'd0, 27'd0, 0, 1), r, t, lat, nd);
    nvec++; if (r !== mks(1, 8'd1, 31'h20000000, 0, 0)) begin nerr++; $display("FAIL plus_zero_result: got %h want %h", r, mks(1, 8'd1, 31'h20000000, 0, 0)); end
    run_op(mk(0, 8'd0, 27'd0, 0, 1), mk(1, 8'd5, 27'd0, 0, 1), r, t, lat, nd);
    nvec++; if (r !== 42'h1) begin nerr++; $display("FAIL both_zero_result: got %h want 1", r); end
  endtask

  task automatic test_saturation();
    logic [41:0] r; logic t; int lat, nd;
    run_op(mk(0, 8'h7F, 27'd0, 0, 0), mk(0, 8'h7F, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (r !== mks(0, 8'h7F, 31'd0, 0, 0)) begin nerr++; $display("FAIL sat_hi_result: got %h want %h", r, mks(0, 8'h7F, 31'd0, 0, 0)); end
    run_op(mk(0, 8'h80, 27'd1, 0, 0), mk(1, 8'h80, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (r !== mks(0, 8'h80, 31'd0, 0, 0)) begin nerr++; $display("FAIL sat_lo_result: got %h want %h", r, mks(0, 8'h80, 31'd0, 0, 0)); end
    nvec++; if (t !== 1'b0) begin nerr++; $display("FAIL sat_lo_trunc: got %b want 0", t); end
  endtask

  task automatic test_back_to_back();
    logic [41:0] er [1000];
    logic        et [1000];
    logic [37:0] a, b;
    for (int i = 0; i < 1008; i++) begin
      @(posedge clk); #1;
      if (i >= 8) begin
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL stream_done[%0d]: got %b want 1", i - 8, done); end
        nvec++; if (result !== er[i-8]) begin nerr++; $display("FAIL stream_result[%0d]: got %h want %h", i - 8, result, er[i-8]); end
        nvec++; if (truncated !== et[i-8]) begin nerr++; $display("FAIL stream_trunc[%0d]: got %b want %b", i - 8, truncated, et[i-8]); end
      end else begin
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL stream_idle_done[%0d]: got %b want 0", i, done); end
      end
      if (i < 1000) begin
        gen_pair(a, b);
        model(a, b, er[i], et[i]);
        in1 = a; in2 = b; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [37:0] a, b;
    logic [41:0] r; logic t; int lat, nd;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      gen_pair(a, b);
      in1 = a; in2 = b; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++; if (result !== 42'h0) begin nerr++; $display("FAIL midrst_result: got %h want 0", result); end
    nvec++; if (truncated !== 1'b0) begin nerr++; $display("FAIL midrst_trunc: got %b want 0", truncated); end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL midrst_done[%0d]: got %b want 0", c, done); end
    end
    run_op(mk(0, 8'd0, 27'h4000000, 0, 0), mk(0, 8'd0, 27'd0, 0, 0), r, t, lat, nd);
    nvec++; if (lat !== 8) begin nerr++; $display("FAIL midrst_relatency: got %0d want 8", lat); end
    nvec++; if (r !== mks(0, 8'd1, 31'h20000000, 0, 0)) begin nerr++; $display("FAIL midrst_reresult: got %h want %h", r, mks(0, 8'd1, 31'h20000000, 0, 0)); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_carry();
    test_cancel();
    test_sticky();
    test_specials();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
